// File: rtl/final_permutation.sv
// final_permutation
// DES inverse initial permutation (IP^-1 / FP) with a valid/ready handshake
// and a 2-entry elastic buffer. Every accepted block is permuted before it is
// stored, so both buffer entries hold permuted data. Blocks leave in order,
// and each output handshake is counted.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   dataIn holds a block to be accepted
//   in_ready   a new block can be accepted this cycle (registered state only)
//   dataIn     preoutput block (R16||L16), vector index k = DES bit k+1
//   out_valid  dataOut holds a permuted block
//   out_ready  downstream accepts dataOut this cycle
//   dataOut    IP^-1(dataIn), the head buffer entry
//   blk_count  output handshakes since reset, modulo 2^CNT_W
module final_permutation #(
  parameter int MAXBITS = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAXBITS-1:0] dataIn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAXBITS-1:0] dataOut,
  output logic [CNT_W-1:0]   blk_count
);

  // dataOut[i] = dataIn[FP_TAB[i]], 0-based
  localparam logic [5:0] FP_TAB [64] = '{
    6'd39, 6'd7, 6'd47, 6'd15, 6'd55, 6'd23, 6'd63, 6'd31,
    6'd38, 6'd6, 6'd46, 6'd14, 6'd54, 6'd22, 6'd62, 6'd30,
    6'd37, 6'd5, 6'd45, 6'd13, 6'd53, 6'd21, 6'd61, 6'd29,
    6'd36, 6'd4, 6'd44, 6'd12, 6'd52, 6'd20, 6'd60, 6'd28,
    6'd35, 6'd3, 6'd43, 6'd11, 6'd51, 6'd19, 6'd59, 6'd27,
    6'd34, 6'd2, 6'd42, 6'd10, 6'd50, 6'd18, 6'd58, 6'd26,
    6'd33, 6'd1, 6'd41, 6'd9,  6'd49, 6'd17, 6'd57, 6'd25,
    6'd32, 6'd0, 6'd40, 6'd8,  6'd48, 6'd16, 6'd56, 6'd24
  };

  logic [MAXBITS-1:0] perm;
  logic [MAXBITS-1:0] head_q, head_d;
  logic [MAXBITS-1:0] tail_q, tail_d;
  logic [1:0]         occ_q, occ_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push, pop;

  // Permutation: pure wiring in front of the buffer
  for (genvar g = 0; g < 64; g++) begin : g_fp
    assign perm[g] = dataIn[FP_TAB[g]];
  end

  // Handshake flags come only from registered occupancy
  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign dataOut   = head_q;
  assign blk_count = cnt_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Buffer is a 2-stage shift structure: head drives dataOut, tail waits
  // behind it. A pop that leaves the buffer empty keeps head untouched, so
  // dataOut holds its last value.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    if (pop) cnt_d = cnt_q + CNT_W'(1);
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = perm;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = perm;
        end else if (push) begin
          tail_d = perm;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d  = 2'd0;
        end
      end
      default: begin
        // Full: in_ready is low, so only a pop can happen
        if (pop) begin
          head_d = tail_q;
          occ_d  = 2'd1;
        end
      end
    endcase
  end

  // Register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_final_permutation.sv
// Directed testbench for final_permutation. Expected FP outputs come from the
// standard DES IP table: FP(a) is the x with IP(x) == a.
module tb_final_permutation;

  localparam logic [5:0] IP_TAB [64] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
    6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
    6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,
    6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,  6'd0,
    6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
    6'd60, 6'd52, 6'd44, 6'd36, 6'd28, 6'd20, 6'd12, 6'd4,
    6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dataIn = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] dataOut;
  logic [15:0] blk_count;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [63:0] w_dataIn = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b0;
  logic [63:0] w_dataOut;
  logic [3:0]  w_blk_count;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  final_permutation #(.MAXBITS(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .dataIn(dataIn),
    .out_valid(out_valid), .out_ready(out_ready), .dataOut(dataOut),
    .blk_count(blk_count)
  );

  final_permutation #(.MAXBITS(64), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .dataIn(w_dataIn),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .dataOut(w_dataOut),
    .blk_count(w_blk_count)
  );

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[i[5:0]] = x[IP_TAB[i[5:0]]];
    return y;
  endfunction

  // Inverse of IP: scatter instead of gather
  function automatic logic [63:0] fp_ref(input logic [63:0] a);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[IP_TAB[j[5:0]]] = a[j[5:0]];
    return y;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (dataOut !== 64'h0) begin failures++; $display("FAIL reset_dataOut got=%h want=0", dataOut); end
    checks++; if (blk_count !== 16'd0) begin failures++; $display("FAIL reset_blk_count got=%0d want=0", blk_count); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_first_block();
    out_ready = 1'b1; in_valid = 1'b1; dataIn = 64'h0000_0000_0000_0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL first_out_valid got=%b want=1", out_valid); end
    checks++; if (dataOut !== 64'h0200_0000_0000_0000) begin failures++; $display("FAIL first_dataOut got=%h want=0200000000000000", dataOut); end
    checks++; if (blk_count !== 16'd0) begin failures++; $display("FAIL first_cnt_before got=%0d want=0", blk_count); end
    @(posedge clk); #1;
    exp_cnt = 16'd1;
    checks++; if (blk_count !== exp_cnt) begin failures++; $display("FAIL first_cnt_after got=%0d want=%0d", blk_count, exp_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL first_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_round_trip();
    logic [63:0] x;
    out_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      x = {$urandom, $urandom};
      dataIn = ip_perm(x); in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || dataOut !== x) begin failures++; $display("FAIL roundtrip_data k=%0d got=%b/%h want=1/%h", k, out_valid, dataOut, x); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL roundtrip_in_ready k=%0d got=%b want=1", k, in_ready); end
      checks++; if (blk_count !== exp_cnt + 16'(k)) begin failures++; $display("FAIL roundtrip_cnt k=%0d got=%0d want=%0d", k, blk_count, exp_cnt + 16'(k)); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1000;
    checks++; if (blk_count !== exp_cnt) begin failures++; $display("FAIL roundtrip_total got=%0d want=%0d", blk_count, exp_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL roundtrip_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, c;
    a = 64'h0123_4567_89AB_CDEF; b = 64'hFEDC_BA98_7654_3210; c = 64'h5A5A_0F0F_C3C3_9696;
    out_ready = 1'b0; in_valid = 1'b1; dataIn = a;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || dataOut !== fp_ref(a)) begin failures++; $display("FAIL bp_after_a got=%b/%h want=1/%h", in_ready, dataOut, fp_ref(a)); end
    dataIn = b;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b want=0", in_ready); end
    dataIn = c;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || dataOut !== fp_ref(a) || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold k=%0d got=%b/%h/%b want=1/%h/0", k, out_valid, dataOut, in_ready, fp_ref(a)); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (dataOut !== fp_ref(b) || in_ready !== 1'b1) begin failures++; $display("FAIL bp_second got=%h/%b want=%h/1", dataOut, in_ready, fp_ref(b)); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || dataOut !== fp_ref(c)) begin failures++; $display("FAIL bp_third got=%b/%h want=1/%h", out_valid, dataOut, fp_ref(c)); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b want=0", out_valid); end
    checks++; if (blk_count !== exp_cnt) begin failures++; $display("FAIL bp_cnt got=%0d want=%0d", blk_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    out_ready = 1'b1; in_valid = 1'b1; dataIn = 64'hDEAD_BEEF_0000_FFFF;
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      v = {32'hA5A5_0000 + 32'(k), 32'h1 << k};
      dataIn = v;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || dataOut !== fp_ref(v)) begin failures++; $display("FAIL b2b k=%0d got=%b/%b/%h want=1/1/%h", k, out_valid, in_ready, dataOut, fp_ref(v)); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd21;
    checks++; if (out_valid !== 1'b0 || blk_count !== exp_cnt) begin failures++; $display("FAIL b2b_drain got=%b/%0d want=0/%0d", out_valid, blk_count, exp_cnt); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1; dataIn = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    dataIn = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_full got=%b/%b want=0/1", in_ready, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
    checks++; if (dataOut !== 64'h0) begin failures++; $display("FAIL mid_dataOut got=%h want=0", dataOut); end
    checks++; if (blk_count !== 16'd0) begin failures++; $display("FAIL mid_cnt got=%0d want=0", blk_count); end
    @(negedge clk) rst_n = 1'b1;
    exp_cnt = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || blk_count !== 16'd0) begin failures++; $display("FAIL mid_stale k=%0d got=%b/%b/%0d want=0/1/0", k, out_valid, in_ready, blk_count); end
    end
  endtask

  task automatic test_counter_wrap();
    w_out_ready = 1'b1;
    for (int e = 0; e < 18; e++) begin
      w_in_valid = (e < 17);
      w_dataIn = 64'(e);
      @(posedge clk); #1;
      checks++; if (w_blk_count !== 4'(e)) begin failures++; $display("FAIL wrap_cnt e=%0d got=%0d want=%0d", e, w_blk_count, 4'(e)); end
      if (e < 17) begin
        checks++; if (w_out_valid !== 1'b1 || w_in_ready !== 1'b1 || w_dataOut !== fp_ref(64'(e))) begin failures++; $display("FAIL wrap_data e=%0d got=%b/%b/%h want=1/1/%h", e, w_out_valid, w_in_ready, w_dataOut, fp_ref(64'(e))); end
      end
    end
    w_in_valid = 1'b0;
    checks++; if (w_out_valid !== 1'b0 || w_blk_count !== 4'd1) begin failures++; $display("FAIL wrap_final got=%b/%0d want=0/1", w_out_valid, w_blk_count); end
  endtask

  initial begin
    test_reset();
    test_first_block();
    test_round_trip();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
